// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
// Shared types and default constants for the mux scan sequencer.
//   scan_state_t : sequencer FSM states
//   DW_DEF       : default sample width
//   SELW_DEF     : default select width (channel count is 2**SELW)
//   SETTLE_DEF   : default number of cycles the select is held before sampling
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2,
        FIN    = 2'd3
    } scan_state_t;

    localparam int DW_DEF     = 4;
    localparam int SELW_DEF   = 3;
    localparam int SETTLE_DEF = 2;

endpackage

// File: rtl/mux_scan_sequencer_next_sel.sv
// scan_next_sel
// Combinational channel search over an enable mask.
//   mask        : channels that may be visited
//   cur         : current channel index
//   wrap        : when no set channel lies above cur, return the lowest one
//   next_sel    : lowest set index strictly above cur (or lowest set if wrapping)
//   found       : next_sel is meaningful
//   first_sel   : lowest set index in the whole mask ("cur = -1" search)
//   first_found : mask has at least one bit set
module scan_next_sel
    import mux_scan_pkg::*;
#(
    parameter int NCH  = 1 << SELW_DEF,
    parameter int SELW = SELW_DEF
) (
    input  logic [NCH-1:0]  mask,
    input  logic [SELW-1:0] cur,
    input  logic            wrap,
    output logic [SELW-1:0] next_sel,
    output logic            found,
    output logic [SELW-1:0] first_sel,
    output logic            first_found
);

    always_comb begin
        next_sel    = '0;
        found       = 1'b0;
        first_sel   = '0;
        first_found = 1'b0;
        // Walk downwards so the lowest qualifying index is the last one written.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_sel   = SELW'(i);
                first_found = 1'b1;
            end
            if (mask[i] && (i > int'(cur))) begin
                next_sel = SELW'(i);
                found    = 1'b1;
            end
        end
        if (!found && wrap && first_found) begin
            next_sel = first_sel;
            found    = 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Drives the select of an NCH:1 x DW mux, visiting every channel set in a
// mask latched at start (lowest index first). For each channel the select is
// held for a settle time, the mux output is captured, and the sample is
// offered downstream on a valid/ready handshake.
//   clk, reset        : clock, asynchronous active-high reset
//   start, en_mask    : begin a scan over en_mask (sampled only when idle)
//   y_in              : mux output (combinationally follows s)
//   s                 : mux select
//   out_data, out_ch  : captured sample and its channel, qualified by out_valid
//   out_valid/out_ready : downstream handshake
//   busy              : not idle
//   done              : single-cycle pulse at the end of a scan
// Build option MUX_SCAN_CONTINUOUS_EN: when the highest channel is handed off
// while start is high, the scan wraps to the lowest channel instead of ending.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int NCH    = 1 << SELW_DEF,
    parameter int SELW   = SELW_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [NCH-1:0]  en_mask,
    input  logic [DW-1:0]   y_in,
    output logic [SELW-1:0] s,
    output logic [DW-1:0]   out_data,
    output logic [SELW-1:0] out_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    // The parameter SETTLE shadows the imported state name, so states are
    // always referenced through the package scope.
    scan_state_t     state_q, state_d;
    logic [SELW-1:0] s_q, s_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [NCH-1:0]  srch_mask;
    logic            wrap_en;
    logic [SELW-1:0] next_sel, first_sel;
    logic            next_found, first_found;

    // One search unit serves both cases: the live en_mask while idle (first
    // channel of a new scan) and the latched mask afterwards (next channel).
    assign srch_mask = (state_q == mux_scan_pkg::IDLE) ? en_mask : mask_q;

`ifdef MUX_SCAN_CONTINUOUS_EN
    assign wrap_en = start;
`else
    assign wrap_en = 1'b0;
`endif

    scan_next_sel #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_next_sel (
        .mask        (srch_mask),
        .cur         (s_q),
        .wrap        (wrap_en),
        .next_sel    (next_sel),
        .found       (next_found),
        .first_sel   (first_sel),
        .first_found (first_found)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            mux_scan_pkg::IDLE: begin
                if (start) begin
                    mask_d = en_mask;
                    if (first_found) begin
                        s_d     = first_sel;
                        cnt_d   = CNT_LOAD;
                        state_d = mux_scan_pkg::SETTLE;
                    end else begin
                        state_d = mux_scan_pkg::FIN;
                    end
                end
            end
            mux_scan_pkg::SETTLE: begin
                if (cnt_q == '0) begin
                    out_data_d = y_in;
                    out_ch_d   = s_q;
                    state_d    = mux_scan_pkg::HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            mux_scan_pkg::HOLD: begin
                // First HOLD cycle only raises valid; the sample was already
                // captured on entry, so y_in is ignored from here on.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (next_found) begin
                        s_d     = next_sel;
                        cnt_d   = CNT_LOAD;
                        state_d = mux_scan_pkg::SETTLE;
                    end else begin
                        state_d = mux_scan_pkg::FIN;
                    end
                end
            end
            mux_scan_pkg::FIN: begin
                state_d = mux_scan_pkg::IDLE;
            end
            default: begin
                state_d = mux_scan_pkg::IDLE;
            end
        endcase

        busy_d = (state_d != mux_scan_pkg::IDLE);
        done_d = (state_d == mux_scan_pkg::FIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= mux_scan_pkg::IDLE;
            s_q         <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign s         = s_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer
// Directed bench for mux_scan_sequencer with an 8:1 x 4-bit mux model on y_in.
// A transaction-level reference (queue of channels still to visit, countdown
// to the next valid sample) is compared against the DUT every cycle, and
// literal expectations pin sample order, stalls, latency and reset behaviour.
// Build option MUX_SCAN_CONTINUOUS_EN adds the wrap-around scan case.
module tb_mux_scan_sequencer;

    localparam int DW = 4, NCH = 8, SELW = 3, SETTLE = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [NCH-1:0]  en_mask = '0;
    logic [DW-1:0]   y_in;
    logic [SELW-1:0] s;
    logic [DW-1:0]   out_data;
    logic [SELW-1:0] out_ch;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            busy;
    logic            done;

    mux_scan_sequencer #(.DW(DW), .NCH(NCH), .SELW(SELW), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset), .start(start), .en_mask(en_mask), .y_in(y_in),
        .s(s), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Mux inputs d0..d7; d2 can be forced to 0 mid-hold.
    logic [3:0] dtab [0:7] = '{4'hF, 4'hE, 4'hD, 4'hB, 4'h7, 4'hC, 4'hA, 4'hC};
    logic       d2_zero = 1'b0;

    function automatic logic [3:0] mux_val(input int ch);
        return (ch == 2 && d2_zero) ? 4'h0 : dtab[ch];
    endfunction

    assign y_in = mux_val(int'(s));

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          q[$];
    int          m_wait;
    logic [7:0]  m_mask;
    int          e_s, e_data, e_ch, e_valid, e_busy, e_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_wait = 0; m_mask = '0;
            e_s = 0; e_data = 0; e_ch = 0; e_valid = 0; e_busy = 0; e_done = 0;
        end else if (e_done != 0) begin
            e_done = 0; e_busy = 0;
        end else if (e_busy == 0) begin
            if (start) begin
                m_mask = en_mask;
                e_busy = 1;
                for (int i = 0; i < NCH; i++) if (m_mask[i]) q.push_back(i);
                if (q.size() == 0) e_done = 1;
                else begin e_s = q.pop_front(); m_wait = SETTLE + 1; end
            end
        end else if (m_wait > 0) begin
            // Sample taken after SETTLE stable cycles, valid one cycle later.
            m_wait--;
            if (m_wait == 1) begin e_data = int'(mux_val(e_s)); e_ch = e_s; end
            if (m_wait == 0) e_valid = 1;
        end else if (e_valid != 0 && out_ready) begin
            e_valid = 0;
            if (q.size() > 0) begin
                e_s = q.pop_front(); m_wait = SETTLE + 1;
            end
`ifdef MUX_SCAN_CONTINUOUS_EN
            else if (start) begin
                for (int i = 0; i < NCH; i++) if (m_mask[i]) q.push_back(i);
                e_s = q.pop_front(); m_wait = SETTLE + 1;
            end
`endif
            else e_done = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("s", int'(s), e_s);
            chk("out_valid", int'(out_valid), e_valid);
            chk("out_data", int'(out_data), e_data);
            chk("out_ch", int'(out_ch), e_ch);
            chk("busy", int'(busy), e_busy);
            chk("done", int'(done), e_done);
        end
    end

    // ---------------- ready driver + monitor ----------------
    int   cyc = 0;
    always @(posedge clk) cyc++;

    logic stall_en = 1'b0;
    int   stall_cnt = 0;
    int   log_ch[$], log_dt[$];
    int   done_cnt = 0, valid_cnt = 0, t_s = 0, last_lat = -1;
    logic [SELW-1:0] prev_s = '0;
    logic prev_v = 1'b0;

    always @(negedge clk) begin
        if (!stall_en) begin
            stall_cnt = 0; d2_zero = 1'b0; out_ready = 1'b1;
        end else if (out_valid && out_ch == 3'd2 && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
            if (stall_cnt == 3) d2_zero = 1'b1;
            chk("stall_data", int'(out_data), 13);
            chk("stall_s", int'(s), 2);
        end else begin
            out_ready = 1'b1;
        end
        if (!reset) begin
            if (out_valid && out_ready) begin
                log_ch.push_back(int'(out_ch)); log_dt.push_back(int'(out_data));
            end
            if (done) done_cnt++;
            if (out_valid) valid_cnt++;
            if (s != prev_s) t_s = cyc;
            if (out_valid && !prev_v) last_lat = cyc - t_s;
        end
        prev_s = s; prev_v = out_valid;
    end

    task automatic chk_tx(input string nm, input int base, input int idx, input int ch, input int dt);
        if (base + idx >= log_ch.size()) chk({nm, "_missing"}, log_ch.size(), base + idx + 1);
        else begin
            chk({nm, "_ch"}, log_ch[base + idx], ch);
            chk({nm, "_data"}, log_dt[base + idx], dt);
        end
    endtask

    task automatic run_scan(input logic [7:0] m, input int hold_start, output int base, output int d0);
        base = log_ch.size(); d0 = done_cnt;
        @(negedge clk); en_mask = m; start = 1'b1;
        repeat (hold_start) @(negedge clk);
        start = 1'b0; en_mask = ~m;   // changes while busy must not matter
        for (int k = 0; k < 300 && done_cnt == d0; k++) @(negedge clk);
        chk("scan_done_seen", done_cnt - d0, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d0, v0;
        repeat (2) @(negedge clk);
        chk("rst_s", int'(s), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_data", int'(out_data), 0);
        reset = 1'b0;
        @(negedge clk);

        // Empty mask: done one cycle later, no valid, s stays 0.
        v0 = valid_cnt;
        en_mask = 8'h00; start = 1'b1;
        @(negedge clk);
        chk("empty_done", int'(done), 1);
        chk("empty_busy", int'(busy), 1);
        start = 1'b0;
        @(negedge clk);
        chk("empty_done_gone", int'(done), 0);
        chk("empty_busy_gone", int'(busy), 0);
        chk("empty_s", int'(s), 0);
        chk("empty_no_valid", valid_cnt - v0, 0);

        // Basic scan, start held an extra cycle (ignored while busy).
        run_scan(8'b0100_0101, 2, base, d0);
        chk("t1_count", log_ch.size() - base, 3);
        chk_tx("t1_0", base, 0, 0, 15);
        chk_tx("t1_1", base, 1, 2, 13);
        chk_tx("t1_2", base, 2, 6, 10);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_busy_low", int'(busy), 0);

        // Stall channel 2 for 5 cycles, d2 changes while held.
        stall_en = 1'b1;
        run_scan(8'b0100_0101, 1, base, d0);
        chk("t2_stall_cycles", stall_cnt, 5);
        stall_en = 1'b0;
        chk("t2_count", log_ch.size() - base, 3);
        chk_tx("t2_0", base, 0, 0, 15);
        chk_tx("t2_1", base, 1, 2, 13);
        chk_tx("t2_2", base, 2, 6, 10);
        @(negedge clk);

        // Single highest channel and its latency from select change.
        run_scan(8'h80, 1, base, d0);
        chk("t4_count", log_ch.size() - base, 1);
        chk_tx("t4_0", base, 0, 7, 12);
        chk("t4_latency", last_lat, SETTLE + 1);

        // Async reset while channel 2 is being held.
        @(negedge clk); en_mask = 8'b0100_0101; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 100 && !(out_valid && out_ch == 3'd2); k++) @(negedge clk);
        chk("t5_reach_hold2", int'(out_valid && out_ch == 3'd2), 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_s", int'(s), 0);
        chk("t5_async_valid", int'(out_valid), 0);
        chk("t5_async_data", int'(out_data), 0);
        chk("t5_async_ch", int'(out_ch), 0);
        chk("t5_async_busy", int'(busy), 0);
        chk("t5_async_done", int'(done), 0);
        @(negedge clk); #2 reset = 1'b0;
        run_scan(8'h01, 1, base, d0);
        chk("t5_count", log_ch.size() - base, 1);
        chk_tx("t5_0", base, 0, 0, 15);

`ifdef MUX_SCAN_CONTINUOUS_EN
        // Continuous scan with start held, then released.
        base = log_ch.size(); d0 = done_cnt;
        @(negedge clk); en_mask = 8'h03; start = 1'b1;
        for (int k = 0; k < 300 && log_ch.size() - base < 6; k++) @(negedge clk);
        chk("cont_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 6; i++) chk_tx("cont", base, i, i % 2, (i % 2 == 0) ? 15 : 14);
        start = 1'b0;
        for (int k = 0; k < 300 && done_cnt == d0; k++) @(negedge clk);
        chk("cont_done", done_cnt - d0, 1);
        chk("cont_last_ch", log_ch[log_ch.size() - 1], 1);
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
